bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
- Multi-digit cascaded BCD down-counter (countdown timer).
- Preset value is loaded, count runs down by one per tick strobe while enabled, and a one-cycle done pulse fires on reaching 0000.
- Companion to the team's BCD up-counters, counting in the opposite direction.
- Drives display digit paths and timeout logic; ticks come from an external prescaler strobe.

Parameters:
- DIGITS, 4, number of cascaded BCD digits; digit 0 is least significant, in bits [3:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-low (0 at a rising clk edge resets the block)
- load  input  1  load request; loads load_val
- load_val  input  4*DIGITS  preset value, packed BCD
- start  input  1  start/resume request
- pause  input  1  pause request
- tick  input  1  count strobe; one decrement per high cycle while running
- bcd_out  output  4*DIGITS  current count, packed BCD
- running  output  1  high while in RUN
- zero  output  1  high when bcd_out is all-zero digits
- done  output  1  one-cycle pulse when count reaches zero from RUN

Behaviour:
- Reset (rst==0 at posedge clk):
  - bcd_out=0, state=IDLE, running=0, done=0.
  - zero=1, since it follows bcd_out.
  - Reset overrides every other input.
- State machine: IDLE, RUN, HOLD.
  - running is registered: high exactly when state==RUN.
- Input priority, per cycle: rst > load > pause > start > tick.
- load:
  - Accepted only in IDLE or HOLD; bcd_out<=load_val on the next edge. State is unchanged.
  - Ignored entirely in RUN.
  - Each loaded digit greater than 9 is clamped to 9, independently per digit.
  - A load cycle ignores start and tick in the same cycle.
- start:
  - In IDLE or HOLD with bcd_out!=0 and no load/pause: state->RUN on the next edge.
  - In IDLE or HOLD with bcd_out==0: ignored, state unchanged.
  - In RUN: no effect.
- pause:
  - In RUN: state->HOLD on the next edge. The tick in that same cycle is NOT applied.
  - In IDLE or HOLD: no effect, but it blocks start in the same cycle.
- tick:
  - Applied only when state==RUN and pause==0; bcd_out decrements by 1 BCD on the next edge.
  - Ignored in IDLE and HOLD.
- Decrement rules:
  - Digit 0 decrements. A digit at 0 becomes 9 and generates a borrow into the next digit.
  - Borrow ripples combinationally through all digits within one cycle, e.g. 1000 -> 0999 in a single tick.
  - Latency from tick to updated bcd_out is 1 clock.
- Terminal count:
  - Trigger: a tick is applied with bcd_out==1, i.e. only digit 0 nonzero and equal to 1.
  - On that edge: bcd_out<=0, state<=IDLE, done<=1.
  - done is high for exactly the one cycle following that edge, then returns to 0.
  - There is no wrap below zero; RUN with bcd_out==0 is unreachable.
- zero is combinational from bcd_out. done is registered.
- Back-to-back ticks are legal: one decrement per cycle.
- Reset mid-RUN (rst==0): next edge yields IDLE and bcd_out=0. No done pulse is generated, and a pending done is cleared.
- load_val, start, pause and tick are sampled only at the rising edge. No glitch or multi-cycle requirement applies.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> bcd_out=0x0000, running=0, zero=1, done=0. Release, then idle 5 cycles -> unchanged.
- Borrow ripple:
  - load_val=0x1001, load=1, then start=1 -> RUN.
  - 3 ticks -> 0x1000, 0x0999, 0x0998.
  - Each step updates 1 cycle after its tick, and running=1 throughout.
- Terminal count: load 0x0002, start, tick 2 cycles back-to-back -> 0x0001 then 0x0000. In the following cycle: done=1 (one cycle only), running=0, zero=1, state IDLE. A further tick leaves 0x0000.
- Pause/resume and blocked load:
  - In RUN at 0x0050, assert pause+tick together -> HOLD, count stays 0x0050.
  - tick in HOLD -> no change.
  - load 0x0300 in HOLD -> 0x0300.
  - start -> RUN; tick -> 0x0299.
  - load during RUN -> ignored.
- Clamp and zero-start:
  - load_val=0xA3F1 -> bcd_out=0x9391.
  - load 0x0000 then start -> remains IDLE, running=0, no done.
- Reset mid-run: RUN at 0x0001 with tick and rst=0 in the same cycle -> bcd_out=0x0000, IDLE, done stays 0.

Source files
------------

// File: rtl/bcd_down_timer.sv
// ---------------------------------------------------------------------------
// bcd_down_timer
// Cascaded packed-BCD countdown timer. A preset is loaded while stopped. The
// count then runs down by one per tick strobe while in RUN. On the transition
// from 1 to 0 the timer drops back to IDLE and pulses done for one cycle.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   synchronous active-low reset
//   load     in   load request (honoured in IDLE/HOLD only)
//   load_val in   preset, packed BCD, digit 0 in [3:0]; digits > 9 clamp to 9
//   start    in   start/resume request (ignored when the count is zero)
//   pause    in   pause request (RUN -> HOLD, also blocks start)
//   tick     in   count strobe, one decrement per high cycle in RUN
//   bcd_out  out  current count, packed BCD (registered)
//   running  out  high while in RUN (registered)
//   zero     out  high when bcd_out is all zero digits
//   done     out  one-cycle pulse after the count reaches zero from RUN
// ---------------------------------------------------------------------------
module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  zero,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           running_q, running_d;
  logic           done_q, done_d;

  // Saturate every digit above 9 to 9, each digit on its own.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Subtract one in BCD. A zero digit becomes 9 and passes the borrow upward,
  // so the borrow ripples through every digit in a single cycle.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Next-state, next-count and done decode. Priority: load > pause > start > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (load) begin
          count_d = bcd_clamp(load_val);
        end else if (pause) begin
          // Pause while stopped only blocks a same-cycle start.
          state_d = state_q;
        end else if (start && (count_q != CNT_ZERO)) begin
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        // load is ignored entirely while running.
        if (pause) begin
          state_d = HOLD;
        end else if (tick) begin
          if (count_q == CNT_ONE) begin
            count_d = CNT_ZERO;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            count_d = bcd_dec(count_q);
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = CNT_ZERO;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= CNT_ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bcd_out = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign zero    = (count_q == CNT_ZERO);

endmodule

// File: tb/tb_bcd_down_timer.sv
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        pause;
  logic        tick;
  logic [15:0] bcd_out;
  logic        running;
  logic        zero;
  logic        done;

  int checks   = 0;
  int failures = 0;

  bcd_down_timer #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tick     (tick),
    .bcd_out  (bcd_out),
    .running  (running),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic        tick;
    logic [15:0] exp_bcd;
    logic        exp_run;
    logic        exp_zero;
    logic        exp_done;
  } vec_t;

  typedef struct packed {
    int          idx;
    logic [15:0] bcd;
    logic        run;
    logic        zro;
    logic        dn;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, input logic ld, input logic [15:0] lv,
                              input logic st, input logic pa, input logic tk,
                              input logic [15:0] eb, input logic er,
                              input logic ez, input logic ed);
    vec_t v;
    v.rst = r; v.load = ld; v.load_val = lv; v.start = st; v.pause = pa; v.tick = tk;
    v.exp_bcd = eb; v.exp_run = er; v.exp_zero = ez; v.exp_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Pop the oldest expected record and compare against current DUT outputs.
  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk($sformatf("row%0d_bcd", e.idx),     bcd_out,        e.bcd);
      chk($sformatf("row%0d_running", e.idx), {15'd0, running}, {15'd0, e.run});
      chk($sformatf("row%0d_zero", e.idx),    {15'd0, zero},    {15'd0, e.zro});
      chk($sformatf("row%0d_done", e.idx),    {15'd0, done},    {15'd0, e.dn});
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    rst = v.rst; load = v.load; load_val = v.load_val;
    start = v.start; pause = v.pause; tick = v.tick;
    e.idx = idx; e.bcd = v.exp_bcd; e.run = v.exp_run; e.zro = v.exp_zero; e.dn = v.exp_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    score();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;

    //          rst ld  load_val  st pa tk   exp_bcd  run zro dn
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h1001, 0, 0, 0, 16'h1001, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h1001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h1000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0999, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0998, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 16'h0998, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h0050, 0, 0, 0, 16'h0050, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0050, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 16'h0050, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0050, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0300, 0, 0, 0, 16'h0300, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0300, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0299, 1, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0777, 0, 0, 0, 16'h0299, 1, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0777, 0, 0, 1, 16'h0298, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 16'h0298, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'hA3F1, 1, 0, 1, 16'h9391, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 16'h9391, 0, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 1, 0, 0, 16'h0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0));

    rst = 1'b0; load = 1'b0; load_val = 16'h0000;
    start = 1'b0; pause = 1'b0; tick = 1'b0;

    // Reset held for two cycles while the other inputs toggle randomly.
    for (int i = 0; i < 2; i++) begin
      load = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1));
      pause = 1'($urandom_range(0, 1)); tick = 1'($urandom_range(0, 1));
      load_val = 16'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("reset%0d_bcd", i), bcd_out, 16'h0000);
      chk($sformatf("reset%0d_running", i), {15'd0, running}, 16'h0000);
      chk($sformatf("reset%0d_zero", i), {15'd0, zero}, 16'h0001);
      chk($sformatf("reset%0d_done", i), {15'd0, done}, 16'h0000);
    end

    for (int i = 0; i < tbl.size(); i++)
      apply(i, tbl[i]);

    // Continuous tick from 0003: done must appear after exactly 3 ticks.
    apply(100, mk(1, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0));
    apply(101, mk(1, 0, 16'h0000, 1, 0, 0, 16'h0003, 1, 0, 0));
    tick = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    tick = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got timeout after %0d cycles expected done", cyc);
    end else begin
      chk("wait_done_cycles", 16'(cyc), 16'd3);
      chk("wait_done_bcd", bcd_out, 16'h0000);
      chk("wait_done_running", {15'd0, running}, 16'h0000);
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", {15'd0, done}, 16'h0000);

    chk("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
